// File: rtl/data_proc_dbg_pkg.sv
// Shared definitions for the data_proc debug blocks: FSM state encoding
// and default sizing constants, also used by the CSR slice.
package data_proc_dbg_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSuspect  = 2'd1,
        StDeadlock = 2'd2,
        StRecover  = 2'd3
    } dl_state_e;

    localparam int unsigned DefNAxis  = 2;
    localparam int unsigned DefThresh = 1024;
    localparam int unsigned DefCntW   = 16;
    localparam int unsigned DefEvtW   = 8;

endpackage

// File: rtl/data_proc_sat_counter.sv
// Saturating up-counter with synchronous clear. clr together with inc
// loads 1, so a new counting window starts with the current cycle.
module data_proc_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    // Clear/restart has priority; increment sticks at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= inc ? Width'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_proc_deadlock_watchdog.sv
// Deadlock watchdog: filters transient back-pressure from the deadlock
// monitor, declares a deadlock after THRESH consecutive blocked cycles,
// latches the blocked AXIS channels, raises a sticky IRQ and counts events.
// Optional feature macro: DEADLOCK_TIMESTAMP_EN adds deadlock_ts, the value
// of a free-running cycle counter captured on the declare edge.
module data_proc_deadlock_watchdog
    import data_proc_dbg_pkg::*;
#(
    parameter int unsigned N_AXIS = DefNAxis,
    parameter int unsigned THRESH = DefThresh,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned EVT_W  = DefEvtW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              block_in,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic              enable,
    input  logic              clear,
    output logic              deadlock_irq,
    output logic [1:0]        deadlock_state,
    output logic [N_AXIS-1:0] blocked_chan,
    output logic [CNT_W-1:0]  block_cycles,
    output logic [EVT_W-1:0]  event_count
`ifdef DEADLOCK_TIMESTAMP_EN
    ,
    output logic [31:0]       deadlock_ts
`endif
);

    dl_state_e         state_q;
    logic              irq_q;
    logic [N_AXIS-1:0] chan_q;
    logic [N_AXIS-1:0] acc_q;

    logic at_thresh;
    logic declare;
    logic ack;
    logic cyc_inc;
    logic cyc_clr;

    assign at_thresh = (block_cycles >= CNT_W'(THRESH - 1));

    // Decision flags shared by the FSM and the two counters.
    always_comb begin
        declare = 1'b0;
        ack     = 1'b0;
        cyc_clr = 1'b0;
        cyc_inc = enable & block_in;
        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    // Every new window restarts the persistence count at 1.
                    cyc_clr = block_in;
                    declare = block_in && (THRESH == 1);
                end
                StSuspect: begin
                    cyc_clr = ~block_in;
                    declare = block_in & at_thresh;
                end
                StDeadlock, StRecover: begin
                    ack     = clear;
                    cyc_clr = clear;
                end
                default: ;
            endcase
        end
    end

    // FSM with sticky status latches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
            chan_q  <= '0;
            acc_q   <= '0;
        end else if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (declare) begin
                        state_q <= StDeadlock;
                        irq_q   <= 1'b1;
                        chan_q  <= axis_block_sigs;
                    end else if (block_in) begin
                        state_q <= StSuspect;
                        acc_q   <= axis_block_sigs;
                    end
                end
                StSuspect: begin
                    if (!block_in) begin
                        state_q <= StIdle;
                        acc_q   <= '0;
                    end else if (declare) begin
                        state_q <= StDeadlock;
                        irq_q   <= 1'b1;
                        chan_q  <= acc_q | axis_block_sigs;
                        acc_q   <= '0;
                    end else begin
                        acc_q <= acc_q | axis_block_sigs;
                    end
                end
                StDeadlock, StRecover: begin
                    if (ack) begin
                        irq_q  <= 1'b0;
                        chan_q <= '0;
                        if (block_in) begin
                            state_q <= StSuspect;
                            acc_q   <= axis_block_sigs;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        state_q <= block_in ? StDeadlock : StRecover;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end else if (state_q == StSuspect) begin
            // Disabling abandons a suspect window; sticky states are kept.
            state_q <= StIdle;
            acc_q   <= '0;
        end
    end

    data_proc_sat_counter #(
        .Width (CNT_W)
    ) u_cycles (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (cyc_inc),
        .clr     (cyc_clr),
        .count   (block_cycles)
    );

    data_proc_sat_counter #(
        .Width (EVT_W)
    ) u_events (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (declare),
        .clr     (1'b0),
        .count   (event_count)
    );

`ifdef DEADLOCK_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    // Free-running cycle counter and capture on the declare edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (declare) begin
                ts_q <= ts_cnt_q;
            end else if (ack) begin
                ts_q <= '0;
            end
        end
    end

    assign deadlock_ts = ts_q;
`endif

    assign deadlock_state = state_q;
    assign deadlock_irq   = irq_q;
    assign blocked_chan   = chan_q;

endmodule

// File: tb/tb_data_proc_deadlock_watchdog.sv
// Directed bench for the deadlock watchdog with THRESH=8. A second instance
// with EVT_W=2 sees the same stimulus to exercise event-count saturation.
module tb_data_proc_deadlock_watchdog;

    logic        clock;
    logic        reset_n;
    logic        block_in;
    logic [1:0]  axis_block_sigs;
    logic        enable;
    logic        clear;

    logic        deadlock_irq;
    logic [1:0]  deadlock_state;
    logic [1:0]  blocked_chan;
    logic [15:0] block_cycles;
    logic [7:0]  event_count;
    logic        irq_s;
    logic [1:0]  state_s;
    logic [1:0]  chan_s;
    logic [15:0] cycles_s;
    logic [1:0]  event_s;
`ifdef DEADLOCK_TIMESTAMP_EN
    logic [31:0] deadlock_ts;
    logic [31:0] ts_s;
`endif

    int total;
    int bad;
    int unsigned tb_cyc;

    data_proc_deadlock_watchdog #(
        .N_AXIS (2),
        .THRESH (8),
        .CNT_W  (16),
        .EVT_W  (8)
    ) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .block_in        (block_in),
        .axis_block_sigs (axis_block_sigs),
        .enable          (enable),
        .clear           (clear),
        .deadlock_irq    (deadlock_irq),
        .deadlock_state  (deadlock_state),
        .blocked_chan    (blocked_chan),
        .block_cycles    (block_cycles),
        .event_count     (event_count)
`ifdef DEADLOCK_TIMESTAMP_EN
        ,
        .deadlock_ts     (deadlock_ts)
`endif
    );

    data_proc_deadlock_watchdog #(
        .N_AXIS (2),
        .THRESH (8),
        .CNT_W  (16),
        .EVT_W  (2)
    ) u_dut_sat (
        .clock           (clock),
        .reset_n         (reset_n),
        .block_in        (block_in),
        .axis_block_sigs (axis_block_sigs),
        .enable          (enable),
        .clear           (clear),
        .deadlock_irq    (irq_s),
        .deadlock_state  (state_s),
        .blocked_chan    (chan_s),
        .block_cycles    (cycles_s),
        .event_count     (event_s)
`ifdef DEADLOCK_TIMESTAMP_EN
        ,
        .deadlock_ts     (ts_s)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side cycle count since reset release, for the timestamp check.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        block_in = 1'b0;
        axis_block_sigs = 2'b00;
        enable = 1'b1;
        clear = 1'b0;
        #12;
        total++;
        if ({deadlock_irq, deadlock_state, blocked_chan, block_cycles, event_count} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got irq=%0b st=%0d chan=%b cyc=%0d evt=%0d, want all 0",
                     deadlock_irq, deadlock_state, blocked_chan, block_cycles, event_count);
        end
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_transient();
        block_in = 1'b1;
        axis_block_sigs = 2'b01;
        repeat (5) step();
        total++;
        if (deadlock_state !== 2'd1 || block_cycles !== 16'd5) begin
            bad++;
            $display("FAIL transient_suspect: got st=%0d cyc=%0d, want st=1 cyc=5",
                     deadlock_state, block_cycles);
        end
        block_in = 1'b0;
        axis_block_sigs = 2'b00;
        step();
        total++;
        if (deadlock_state !== 2'd0 || block_cycles !== 16'd0 || deadlock_irq !== 1'b0
            || event_count !== 8'd0 || blocked_chan !== 2'b00) begin
            bad++;
            $display("FAIL transient_drop: got st=%0d cyc=%0d irq=%0b evt=%0d chan=%b, want 0s",
                     deadlock_state, block_cycles, deadlock_irq, event_count, blocked_chan);
        end
    endtask

    task automatic test_declare();
        block_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            axis_block_sigs = (i <= 4) ? 2'b01 : 2'b10;
            step();
            if (i == 7) begin
                total++;
                if (deadlock_irq !== 1'b0 || deadlock_state !== 2'd1 || block_cycles !== 16'd7) begin
                    bad++;
                    $display("FAIL pre_declare: got irq=%0b st=%0d cyc=%0d, want irq=0 st=1 cyc=7",
                             deadlock_irq, deadlock_state, block_cycles);
                end
            end
            if (i == 8) begin
                total++;
                if (deadlock_irq !== 1'b1 || deadlock_state !== 2'd2 || blocked_chan !== 2'b11
                    || event_count !== 8'd1 || block_cycles !== 16'd8) begin
                    bad++;
                    $display("FAIL declare: got irq=%0b st=%0d chan=%b evt=%0d cyc=%0d, want 1 2 11 1 8",
                             deadlock_irq, deadlock_state, blocked_chan, event_count, block_cycles);
                end
`ifdef DEADLOCK_TIMESTAMP_EN
                total++;
                if (deadlock_ts !== 32'(tb_cyc - 1)) begin
                    bad++;
                    $display("FAIL timestamp: got %0d, want %0d", deadlock_ts, tb_cyc - 1);
                end
`endif
            end
        end
        total++;
        if (block_cycles !== 16'd20 || deadlock_state !== 2'd2) begin
            bad++;
            $display("FAIL deadlock_count: got cyc=%0d st=%0d, want cyc=20 st=2",
                     block_cycles, deadlock_state);
        end
    endtask

    task automatic test_recover();
        block_in = 1'b0;
        axis_block_sigs = 2'b00;
        repeat (3) step();
        total++;
        if (deadlock_state !== 2'd3 || deadlock_irq !== 1'b1 || blocked_chan !== 2'b11) begin
            bad++;
            $display("FAIL recover: got st=%0d irq=%0b chan=%b, want st=3 irq=1 chan=11",
                     deadlock_state, deadlock_irq, blocked_chan);
        end
        block_in = 1'b1;
        step();
        total++;
        if (deadlock_state !== 2'd2 || event_count !== 8'd1 || deadlock_irq !== 1'b1) begin
            bad++;
            $display("FAIL re_deadlock: got st=%0d evt=%0d irq=%0b, want st=2 evt=1 irq=1",
                     deadlock_state, event_count, deadlock_irq);
        end
        block_in = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (deadlock_state !== 2'd0 || deadlock_irq !== 1'b0 || blocked_chan !== 2'b00
            || block_cycles !== 16'd0 || event_count !== 8'd1) begin
            bad++;
            $display("FAIL clear_idle: got st=%0d irq=%0b chan=%b cyc=%0d evt=%0d, want 0 0 00 0 1",
                     deadlock_state, deadlock_irq, blocked_chan, block_cycles, event_count);
        end
    endtask

    task automatic test_clear_restart();
        block_in = 1'b1;
        axis_block_sigs = 2'b01;
        repeat (8) step();
        block_in = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (deadlock_state !== 2'd1 || block_cycles !== 16'd1 || deadlock_irq !== 1'b0
            || blocked_chan !== 2'b00 || event_count !== 8'd2) begin
            bad++;
            $display("FAIL clear_restart: got st=%0d cyc=%0d irq=%0b chan=%b evt=%0d, want 1 1 0 00 2",
                     deadlock_state, block_cycles, deadlock_irq, blocked_chan, event_count);
        end
        repeat (6) step();
        total++;
        if (deadlock_irq !== 1'b0 || block_cycles !== 16'd7) begin
            bad++;
            $display("FAIL restart_window: got irq=%0b cyc=%0d, want irq=0 cyc=7",
                     deadlock_irq, block_cycles);
        end
        step();
        total++;
        if (deadlock_irq !== 1'b1 || event_count !== 8'd3 || blocked_chan !== 2'b01) begin
            bad++;
            $display("FAIL second_declare: got irq=%0b evt=%0d chan=%b, want irq=1 evt=3 chan=01",
                     deadlock_irq, event_count, blocked_chan);
        end
        block_in = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_async_reset();
        block_in = 1'b1;
        axis_block_sigs = 2'b10;
        repeat (6) step();
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({deadlock_irq, deadlock_state, blocked_chan, block_cycles, event_count} !== 29'd0) begin
            bad++;
            $display("FAIL async_reset: got irq=%0b st=%0d chan=%b cyc=%0d evt=%0d, want all 0",
                     deadlock_irq, deadlock_state, blocked_chan, block_cycles, event_count);
        end
        #2 reset_n = 1'b1;
        repeat (7) step();
        total++;
        if (deadlock_irq !== 1'b0 || deadlock_state !== 2'd1 || block_cycles !== 16'd7) begin
            bad++;
            $display("FAIL post_reset_window: got irq=%0b st=%0d cyc=%0d, want irq=0 st=1 cyc=7",
                     deadlock_irq, deadlock_state, block_cycles);
        end
        step();
        total++;
        if (deadlock_irq !== 1'b1 || event_count !== 8'd1) begin
            bad++;
            $display("FAIL post_reset_declare: got irq=%0b evt=%0d, want irq=1 evt=1",
                     deadlock_irq, event_count);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) begin
            block_in = 1'b0;
            clear = 1'b1;
            step();
            clear = 1'b0;
            block_in = 1'b1;
            repeat (8) step();
        end
        total++;
        if (event_count !== 8'd5 || event_s !== 2'd3 || irq_s !== 1'b1) begin
            bad++;
            $display("FAIL event_saturate: got evt=%0d evt_sat=%0d irq_sat=%0b, want 5 3 1",
                     event_count, event_s, irq_s);
        end
    endtask

    task automatic test_enable();
        block_in = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        enable = 1'b0;
        block_in = 1'b1;
        repeat (3) step();
        total++;
        if (deadlock_state !== 2'd0 || block_cycles !== 16'd0 || event_count !== 8'd5) begin
            bad++;
            $display("FAIL enable_off: got st=%0d cyc=%0d evt=%0d, want st=0 cyc=0 evt=5",
                     deadlock_state, block_cycles, event_count);
        end
        enable = 1'b1;
        step();
        total++;
        if (deadlock_state !== 2'd1 || block_cycles !== 16'd1) begin
            bad++;
            $display("FAIL enable_on: got st=%0d cyc=%0d, want st=1 cyc=1",
                     deadlock_state, block_cycles);
        end
        block_in = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_transient();
        test_declare();
        test_recover();
        test_clear_restart();
        test_async_reset();
        test_saturate();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
